// File: rtl/mmv_sram_bridge_if.sv
// rtl/mmv_sram_bridge_if.sv - request-side bus between a memory-mapped master and mmv_sram_bridge
interface mmv_sram_bridge_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] s_addr;
  logic              s_wreq;
  logic [DWIDTH-1:0] s_wdat;
  logic              s_rreq;
  logic [DWIDTH-1:0] s_rdat;
  logic              s_rval;
  logic              s_busy;

  modport master (output s_addr, s_wreq, s_wdat, s_rreq, input  s_rdat, s_rval, s_busy);
  modport slave  (input  s_addr, s_wreq, s_wdat, s_rreq, output s_rdat, s_rval, s_busy);
endinterface

// File: rtl/mmv_sram_bridge.sv
// rtl/mmv_sram_bridge.sv - memory-mapped request bridge onto a fixed-latency single-port SRAM
// Registers requests onto the RAM port, tracks in-flight reads, inserts turnaround gaps.
module mmv_sram_bridge #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int RDLAT  = 1,
  parameter int TA     = 1
) (
  input  logic              clk,
  input  logic              reset,
  mmv_sram_bridge_if.slave  bus,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_wdat,
  output logic              ram_re,
  input  logic [DWIDTH-1:0] ram_rdat
);
  localparam int   TAW    = (TA > 0) ? $clog2(TA + 1) : 1;
  localparam bit   HAS_TA = (TA != 0);
  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  logic             last_dir;
  logic [TAW-1:0]   ta_cnt;
  logic [RDLAT:0]   vld_pipe;
  logic             req;
  logic             req_dir;
  logic             dir_change;
  logic             draining;
  logic             busy;
  logic             accept;

  // A write must wait for every outstanding read to return before the bus may flip.
  always_comb begin
    req        = bus.s_wreq | bus.s_rreq;
    req_dir    = bus.s_wreq ? DIR_WR : DIR_RD;
    dir_change = req && (req_dir != last_dir);
    draining   = bus.s_wreq && (vld_pipe != '0);
    busy       = req && ((ta_cnt != '0) || (dir_change && HAS_TA) || draining);
    accept     = req && !busy;
  end

  assign bus.s_busy = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dir   <= DIR_WR;
      ta_cnt     <= '0;
      vld_pipe   <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdat   <= '0;
      bus.s_rval <= 1'b0;
      bus.s_rdat <= '0;
    end else begin
      ram_we     <= accept && (req_dir == DIR_WR);
      ram_re     <= accept && (req_dir == DIR_RD);
      vld_pipe   <= {vld_pipe[RDLAT-1:0], accept && (req_dir == DIR_RD)};
      bus.s_rval <= vld_pipe[RDLAT];
      if (vld_pipe[RDLAT]) begin
        bus.s_rdat <= ram_rdat;
      end
      if (accept) begin
        ram_addr <= bus.s_addr;
        last_dir <= req_dir;
        if (req_dir == DIR_WR) begin
          ram_wdat <= bus.s_wdat;
        end
      end
      // The gap is claimed for the new direction up front; accept waits for the count to expire.
      if (ta_cnt != '0) begin
        ta_cnt <= ta_cnt - TAW'(1);
      end else if (HAS_TA && dir_change && !draining) begin
        ta_cnt   <= TAW'(TA);
        last_dir <= req_dir;
      end
    end
  end
endmodule

// File: doc/mmv_sram_bridge.md
# mmv_sram_bridge

Memory-mapped slave bridge between a single-master request interface (address, write/read strobes, busy backpressure, read-valid return) and a synchronous single-port SRAM with shared read/write direction and fixed read latency. It sits directly downstream of RAM test masters and other memory-mapped masters in the design. It registers requests onto the RAM port and tracks in-flight reads so that each one returns a read-valid pulse. It also inserts bus-turnaround gaps when the access direction changes.

## Interface
- AWIDTH, 8, address width
- DWIDTH, 8, data width
- RDLAT, 1, RAM read latency in clocks from sampled ram_re to valid ram_rdat (legal ≥ 1)
- TA, 1, idle turnaround clocks inserted on direction change (legal ≥ 0)

One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset
- clk  in  1  clock
- s_addr  in  AWIDTH  request address
- s_wreq  in  1  write request, held until accepted
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request, held until accepted
- s_rdat  out  DWIDTH  read data, valid with s_rval
- s_rval  out  1  single-cycle read-data-valid pulse
- s_busy  out  1  request not accepted this cycle
- ram_addr  out  AWIDTH  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdat  out  DWIDTH  RAM write data
- ram_re  out  1  RAM read strobe
- ram_rdat  in  DWIDTH  RAM read data

## Operation
- Request direction: write if s_wreq, else read if s_rreq. If both are high, the write wins and the read is not issued that cycle; the master keeps s_rreq high.
- Accept condition: (s_wreq | s_rreq) & ~s_busy. s_busy is combinational from registered state and the current request strobes. It is 0 when no request is present.
- State: last_dir register (reset = write), turnaround counter ta_cnt (width $clog2(TA+1), min 1), in-flight pipe vld_pipe[RDLAT:0].
- s_busy = 1 when any of the following holds:
  - ta_cnt ≠ 0
  - a request is present, its direction ≠ last_dir, and TA ≠ 0
  - a write request is present while any vld_pipe bit is set (read drain)
- Direction change with ta_cnt = 0 and TA ≠ 0: load ta_cnt ← TA and last_dir ← new direction.
  - ta_cnt decrements to 0.
  - The request is accepted on the first cycle with ta_cnt = 0 and a matching direction.
- Direction change with TA = 0: last_dir updates on accept; no gap is inserted.
- Read→write: the read drain and the turnaround both apply. The turnaround starts only once the pipe is empty.
- Write→read: no drain is needed.
- On accepted write: next cycle ram_we=1, ram_addr=s_addr, ram_wdat=s_wdat.
- On accepted read: next cycle ram_re=1, ram_addr=s_addr, and a 1 is shifted into vld_pipe[0].
- vld_pipe shifts by one every clock. When vld_pipe[RDLAT] is set, s_rdat ← ram_rdat and s_rval=1 for exactly one cycle.
- Requests are accepted back-to-back, one per clock, while the direction is unchanged. Up to RDLAT+1 reads are in flight; no counter can overflow.
- ram_we and ram_re are never high in the same cycle.
- ram_addr and ram_wdat hold their last value when no strobe is active.

## Timing
- Reset values: s_rval=0, s_rdat=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdat=0.
- Internal reset values: ta_cnt=0, vld_pipe=0, last_dir=write.
- s_busy after reset: 0 for a write, 1 for a read (direction change) when TA ≠ 0.
- Write latency: accept in cycle N gives ram_we high in cycle N+1.
- Read latency:
  - accept in cycle N
  - ram_re high in cycle N+1
  - ram_rdat valid in cycle N+1+RDLAT
  - s_rval high in cycle N+2+RDLAT (total RDLAT+2 clocks)
- Turnaround cost: s_busy is high for TA+1 consecutive cycles starting in the first cycle the new-direction request is presented.
- Read→write cost: s_busy is high while reads drain, then for TA+1 more cycles.
- Reset mid-operation: all in-flight reads are discarded with no s_rval, and any turnaround is cancelled. Requests are evaluated normally from the first cycle after reset deasserts.

## Test plan
- Write then read, RDLAT=1, TA=1, addr 0x00:
  - wreq with data 0x01 in cycle 0 → s_busy=0 and ram_we=1 in cycle 1.
  - rreq in cycle 1 → s_busy high in cycles 1–2, accepted in cycle 3, ram_re in cycle 4.
  - ram_rdat=0x01 in cycle 5 → s_rval=1 and s_rdat=0x01 in cycle 6.
- Back-to-back reads: 4 reads in cycles 0–3 with RDLAT=2 → s_rval high in cycles 4–7 with data returned in order; s_busy stays 0.
- Read→write drain: write presented the cycle after the last read is accepted, RDLAT=3, TA=2 → s_busy stays high until the pipe is empty plus 3 cycles; ram_we never coincides with a pending s_rval slot.
- Simultaneous s_wreq and s_rreq (last_dir=write) → only ram_we pulses that cycle, no ram_re; the read is issued after deassertion of s_wreq plus TA+1 busy cycles.
- Reset asserted while 2 reads are in flight → no s_rval afterwards, and all outputs are 0 the cycle after reset.
- TA=0 alternating write/read every cycle → s_busy=0 on every write→read change; each read→write change is stalled only by the drain.
